// File: rtl/registro_lectura_eventos.sv
// -----------------------------------------------------------------------------
// registro_lectura_eventos
//
// This block is the read side of the PicoBlaze register bank. It captures RTC
// transaction completions and front-panel event pulses into sticky registers.
// PicoBlaze reads them through a registered port_id decoder. Each read clears
// what it returned, and a level interrupt stays high while anything is pending.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           asynchronous reset, active-low
//   EN            block enable; when low, outputs go to zero and state is held
//   R_Strobe      PicoBlaze read_strobe, one-cycle pulse
//   port_id       PicoBlaze port address
//   listo         RTC transaction done; its rising edge is the capture event
//   dato_rtc      RTC read data, valid in the cycle listo rises
//   evento        single-cycle event pulses from the button debouncers
//   port_in       registered read data to PicoBlaze in_port
//   interrupcion  level interrupt request
//
// Status byte layout: [0] dato_valido, [1] overrun, [3:2] zero, [7:4] ev_latch
// -----------------------------------------------------------------------------
module registro_lectura_eventos #(
   parameter logic [7:0] PORT_STATUS = 8'h10,
   parameter logic [7:0] PORT_DATA   = 8'h11,
   parameter logic [7:0] PORT_OVR    = 8'h12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic       R_Strobe,
   input  logic [7:0] port_id,
   input  logic       listo,
   input  logic [7:0] dato_rtc,
   input  logic [3:0] evento,
   output logic [7:0] port_in,
   output logic       interrupcion
);

   // Sticky state
   logic       listo_q;
   logic [7:0] data_reg;
   logic       dato_valido;
   logic       overrun;
   logic [3:0] ev_latch;
   logic [7:0] ovr_cnt;

   // Next-state values
   logic [7:0] data_nxt;
   logic       dato_valido_nxt;
   logic       overrun_nxt;
   logic [3:0] ev_latch_nxt;
   logic [7:0] ovr_cnt_nxt;
   logic [7:0] port_in_nxt;
   logic       interrupcion_nxt;

   // Decoded events for this cycle
   logic       captura;
   logic       rd;
   logic       clr_status;
   logic       clr_data;
   logic       clr_ovr;
   logic       ovr_event;
   logic [7:0] status_byte;

   // listo_q tracks listo even while EN is low. Because of that, an edge seen
   // while disabled has already been absorbed and is never captured late.
   assign captura     = listo & ~listo_q & EN;
   assign rd          = R_Strobe & EN;
   assign clr_status  = rd & (port_id == PORT_STATUS);
   assign clr_data    = rd & (port_id == PORT_DATA);
   assign clr_ovr     = rd & (port_id == PORT_OVR);
   // A capture that lands on a PORT_DATA read is not an overrun, because the
   // old word is consumed in that same cycle.
   assign ovr_event   = captura & dato_valido & ~clr_data;
   assign status_byte = {ev_latch, 2'b00, overrun, dato_valido};

   // NOTE: every output of this always_comb gets a default value first, so no
   // path can leave it unassigned. A missing default would infer a latch.
   always_comb begin
      data_nxt         = data_reg;
      dato_valido_nxt  = dato_valido;
      overrun_nxt      = overrun;
      ev_latch_nxt     = ev_latch;
      ovr_cnt_nxt      = ovr_cnt;
      port_in_nxt      = 8'h00;
      interrupcion_nxt = 1'b0;

      // The clears are applied first and the sets after, so a set and a clear
      // on the same bit in the same cycle leave the bit at 1.
      if (clr_status) begin
         ev_latch_nxt = 4'h0;
         overrun_nxt  = 1'b0;
      end
      if (clr_data) begin
         dato_valido_nxt = 1'b0;
      end
      if (clr_ovr) begin
         ovr_cnt_nxt = 8'h00;
      end

      if (captura) begin
         data_nxt        = dato_rtc;
         dato_valido_nxt = 1'b1;
      end
      if (ovr_event) begin
         overrun_nxt = 1'b1;
         // When the counter is cleared in this cycle, the increment starts
         // again from zero. Otherwise the counter saturates at 8'hFF.
         if (clr_ovr) begin
            ovr_cnt_nxt = 8'h01;
         end else if (ovr_cnt != 8'hFF) begin
            ovr_cnt_nxt = ovr_cnt + 8'd1;
         end
      end
      if (EN) begin
         ev_latch_nxt = ev_latch_nxt | evento;
      end

      // The read mux uses the current (pre-clear) values. In the cycle a clear
      // takes effect, PicoBlaze still sees the word it is consuming.
      if (EN) begin
         case (port_id)
            PORT_STATUS: port_in_nxt = status_byte;
            PORT_DATA:   port_in_nxt = data_reg;
            PORT_OVR:    port_in_nxt = ovr_cnt;
            default:     port_in_nxt = 8'h00;
         endcase
         interrupcion_nxt = dato_valido_nxt | overrun_nxt | (|ev_latch_nxt);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then sample together on the edge, whatever order the statements are in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         listo_q      <= 1'b0;
         data_reg     <= 8'h00;
         dato_valido  <= 1'b0;
         overrun      <= 1'b0;
         ev_latch     <= 4'h0;
         ovr_cnt      <= 8'h00;
         port_in      <= 8'h00;
         interrupcion <= 1'b0;
      end else begin
         listo_q      <= listo;
         data_reg     <= data_nxt;
         dato_valido  <= dato_valido_nxt;
         overrun      <= overrun_nxt;
         ev_latch     <= ev_latch_nxt;
         ovr_cnt      <= ovr_cnt_nxt;
         port_in      <= port_in_nxt;
         interrupcion <= interrupcion_nxt;
      end
   end

endmodule

// File: tb/tb_registro_lectura_eventos.sv
// -----------------------------------------------------------------------------
// tb_registro_lectura_eventos
//
// Testbench for registro_lectura_eventos. The directed scenarios check against
// hand-derived constants. A randomized phase checks against a behavioural
// model that applies a cycle's reads (clears) first and its events (sets)
// after.
// -----------------------------------------------------------------------------
module tb_registro_lectura_eventos;

   localparam logic [7:0] P_STATUS = 8'h10;
   localparam logic [7:0] P_DATA   = 8'h11;
   localparam logic [7:0] P_OVR    = 8'h12;

   logic       clk;
   logic       rst;
   logic       EN;
   logic       R_Strobe;
   logic [7:0] port_id;
   logic       listo;
   logic [7:0] dato_rtc;
   logic [3:0] evento;
   logic [7:0] port_in;
   logic       interrupcion;

   int n_cmp;
   int n_bad;

   // Behavioural model state
   logic [7:0] m_data;
   bit         m_valid;
   bit         m_overrun;
   logic [3:0] m_ev;
   int         m_cnt;
   bit         m_listo_prev;
   logic [7:0] m_port_in;
   bit         m_irq;

   registro_lectura_eventos #(
      .PORT_STATUS (P_STATUS),
      .PORT_DATA   (P_DATA),
      .PORT_OVR    (P_OVR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .EN           (EN),
      .R_Strobe     (R_Strobe),
      .port_id      (port_id),
      .listo        (listo),
      .dato_rtc     (dato_rtc),
      .evento       (evento),
      .port_in      (port_in),
      .interrupcion (interrupcion)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_data = 8'h00; m_valid = 0; m_overrun = 0; m_ev = 4'h0;
      m_cnt = 0; m_listo_prev = 0; m_port_in = 8'h00; m_irq = 0;
   endtask

   // Advance the model by one rising edge, using the inputs that were stable
   // before that edge.
   task automatic model_step();
      bit new_word;
      bit reading;
      bit consumed;
      bit lost_word;
      new_word  = EN && listo && !m_listo_prev;
      reading   = EN && R_Strobe;
      consumed  = reading && (port_id == P_DATA);
      lost_word = new_word && m_valid && !consumed;
      if (!EN) m_port_in = 8'h00;
      else if (port_id == P_STATUS) m_port_in = {m_ev, 2'b00, m_overrun, m_valid};
      else if (port_id == P_DATA) m_port_in = m_data;
      else if (port_id == P_OVR) m_port_in = 8'(m_cnt);
      else m_port_in = 8'h00;
      if (reading && port_id == P_STATUS) begin m_ev = 4'h0; m_overrun = 0; end
      if (consumed) m_valid = 0;
      if (reading && port_id == P_OVR) m_cnt = 0;
      if (new_word) begin m_data = dato_rtc; m_valid = 1; end
      if (lost_word) begin
         m_overrun = 1;
         m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
      if (EN) m_ev = m_ev | evento;
      m_irq = EN && (m_valid || m_overrun || m_ev != 4'h0);
      m_listo_prev = listo;
   endtask

   // Drive one cycle of inputs, then let the clock edge pass. Call this away
   // from an edge; it returns 1 time unit after the rising edge.
   task automatic tick(input logic en_i, input logic rs_i, input logic [7:0] pid_i,
                       input logic listo_i, input logic [7:0] dato_i,
                       input logic [3:0] ev_i);
      EN = en_i; R_Strobe = rs_i; port_id = pid_i;
      listo = listo_i; dato_rtc = dato_i; evento = ev_i;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; EN = 1'b1; R_Strobe = 1'b0; port_id = 8'h00;
      listo = 1'b0; dato_rtc = 8'h00; evento = 4'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL reset_hold got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
      rst = 1'b1;
      tick(1, 0, 8'h00, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL reset_idle got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
      tick(1, 0, P_OVR, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_ovr got port_in=%h want 00", port_in);
      end
   endtask

   task automatic test_capture();
      tick(1, 0, 8'h00, 1, 8'h5A, 4'h0);
      tick(1, 0, P_STATUS, 1, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b1, 8'h01}) begin
         n_bad++;
         $display("FAIL cap_status got irq=%b port_in=%h want irq=1 port_in=01", interrupcion, port_in);
      end
      tick(1, 1, P_DATA, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b0, 8'h5A}) begin
         n_bad++;
         $display("FAIL cap_read got irq=%b port_in=%h want irq=0 port_in=5a", interrupcion, port_in);
      end
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL cap_after got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
   endtask

   task automatic test_overrun();
      tick(1, 0, 8'h00, 1, 8'hA5, 4'h0);
      tick(1, 0, 8'h00, 0, 8'h00, 4'h0);
      tick(1, 0, 8'h00, 1, 8'h3C, 4'h0);
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h03) begin
         n_bad++; $display("FAIL ovr_status got %h want 03", port_in);
      end
      tick(1, 0, P_DATA, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h3C) begin
         n_bad++; $display("FAIL ovr_data got %h want 3c", port_in);
      end
      tick(1, 0, P_OVR, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h01) begin
         n_bad++; $display("FAIL ovr_cnt got %h want 01", port_in);
      end
      tick(1, 1, P_STATUS, 0, 8'h00, 4'h0);
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h01) begin
         n_bad++; $display("FAIL ovr_clr_status got %h want 01", port_in);
      end
      tick(1, 1, P_DATA, 0, 8'h00, 4'h0);
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL ovr_clr_data got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
      tick(1, 1, P_OVR, 0, 8'h00, 4'h0);
      tick(1, 0, P_OVR, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h00) begin
         n_bad++; $display("FAIL ovr_cnt_clr got %h want 00", port_in);
      end
   endtask

   task automatic test_events();
      tick(1, 0, 8'h00, 0, 8'h00, 4'b1010);
      tick(1, 1, P_STATUS, 0, 8'h00, 4'b0001);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b1, 8'hA0}) begin
         n_bad++;
         $display("FAIL ev_read got irq=%b port_in=%h want irq=1 port_in=a0", interrupcion, port_in);
      end
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b1, 8'h10}) begin
         n_bad++;
         $display("FAIL ev_set_wins got irq=%b port_in=%h want irq=1 port_in=10", interrupcion, port_in);
      end
      tick(1, 1, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b0, 8'h10}) begin
         n_bad++;
         $display("FAIL ev_clear got irq=%b port_in=%h want irq=0 port_in=10", interrupcion, port_in);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         tick(1, 0, 8'h00, 1, 8'(i), 4'h0);
         tick(1, 0, 8'h00, 0, 8'h00, 4'h0);
      end
      tick(1, 0, P_OVR, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'hFF) begin
         n_bad++; $display("FAIL sat_cnt got %h want ff", port_in);
      end
      tick(1, 0, P_DATA, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'd43) begin
         n_bad++; $display("FAIL sat_data got %h want 2b", port_in);
      end
      tick(1, 1, P_OVR, 1, 8'hEE, 4'h0);
      n_cmp++;
      if (port_in !== 8'hFF) begin
         n_bad++; $display("FAIL sat_read got %h want ff", port_in);
      end
      tick(1, 0, P_OVR, 0, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h01) begin
         n_bad++; $display("FAIL sat_inc_wins got %h want 01", port_in);
      end
      tick(1, 1, P_DATA, 0, 8'h00, 4'h0);
      tick(1, 1, P_STATUS, 0, 8'h00, 4'h0);
      tick(1, 1, P_OVR, 0, 8'h00, 4'h0);
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL sat_cleanup got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
   endtask

   task automatic test_disable_and_reset();
      tick(1, 0, 8'h00, 1, 8'h77, 4'h0);
      tick(1, 0, 8'h00, 0, 8'h00, 4'h0);
      tick(0, 1, P_DATA, 1, 8'h99, 4'hF);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL dis_out got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
      tick(0, 1, P_STATUS, 1, 8'h99, 4'h0);
      tick(1, 0, P_DATA, 1, 8'h99, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== {1'b1, 8'h77}) begin
         n_bad++;
         $display("FAIL dis_held got irq=%b port_in=%h want irq=1 port_in=77", interrupcion, port_in);
      end
      tick(1, 0, P_STATUS, 1, 8'h00, 4'h0);
      n_cmp++;
      if (port_in !== 8'h01) begin
         n_bad++; $display("FAIL dis_no_capture got %h want 01", port_in);
      end
      tick(1, 0, P_DATA, 1, 8'h00, 4'h0);
      #3 rst = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL async_rst got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
      #2 rst = 1'b1;
      tick(1, 0, P_DATA, 0, 8'h00, 4'h0);
      tick(1, 0, P_STATUS, 0, 8'h00, 4'h0);
      n_cmp++;
      if ({interrupcion, port_in} !== 9'h000) begin
         n_bad++;
         $display("FAIL post_rst got irq=%b port_in=%h want irq=0 port_in=00", interrupcion, port_in);
      end
   endtask

   task automatic test_random();
      logic       en_r;
      logic       rs_r;
      logic [7:0] pid_r;
      logic       listo_r;
      logic [3:0] ev_r;
      for (int i = 0; i < 600; i++) begin
         en_r    = ($urandom_range(0, 9) != 0);
         rs_r    = ($urandom_range(0, 3) == 0);
         listo_r = 1'($urandom_range(0, 1));
         ev_r    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
         case ($urandom_range(0, 3))
            0:       pid_r = P_STATUS;
            1:       pid_r = P_DATA;
            2:       pid_r = P_OVR;
            default: pid_r = 8'($urandom);
         endcase
         tick(en_r, rs_r, pid_r, listo_r, 8'($urandom), ev_r);
         n_cmp++;
         if (port_in !== m_port_in || interrupcion !== m_irq) begin
            n_bad++;
            $display("FAIL rand_%0d got irq=%b port_in=%h want irq=%b port_in=%h",
                     i, interrupcion, port_in, m_irq, m_port_in);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_capture();
      test_overrun();
      test_events();
      test_saturation();
      test_disable_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
